// File: rtl/if_mem_resp.sv
// if_mem_resp: instruction-memory responder on the memory end of the fetch bus.
// Accepts word fetch requests, reads a word array with a fixed RD_LATENCY,
// and returns instruction plus error flags through a small FWFT output FIFO.
// A loader write port fills the array at any time, before or during fetch.
// Optional build macro: IF_MEM_PARITY_EN adds one even-parity bit per word and
// the ld_par_inj_i port; a parity mismatch on read reports as a bus error.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, and a responder holding valid keeps its
// payload stable until the transfer happens.
module if_mem_resp #(
  parameter int                      PC_WIDTH    = 32,
  parameter int                      INSTR_WIDTH = 32,
  parameter int                      MEM_DEPTH   = 1024,
  parameter logic [PC_WIDTH-1:0]     BASE_ADDR   = 32'h0000_0000,
  parameter int                      RD_LATENCY  = 1,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 32'h0000_0013
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [PC_WIDTH-1:0]           req_pc_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [INSTR_WIDTH-1:0]        rsp_instr_o,
  output logic                          rsp_misalign_o,
  output logic                          rsp_bus_err_o,
`ifdef IF_MEM_PARITY_EN
  input  logic                          ld_par_inj_i,
`endif
  input  logic                          ld_we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0]  ld_addr_i,
  input  logic [INSTR_WIDTH-1:0]        ld_data_i
);

  localparam int AW     = $clog2(MEM_DEPTH);
  localparam int PIPE_N = RD_LATENCY - 1;   // register stages ahead of the FIFO write
  localparam int FIFO_D = RD_LATENCY + 1;
  localparam int PW     = $clog2(FIFO_D);
  localparam int CW     = $clog2(FIFO_D + 1);
  localparam logic [PC_WIDTH-1:0] DEPTH_W = PC_WIDTH'(MEM_DEPTH);
`ifdef IF_MEM_PARITY_EN
  localparam int MW = INSTR_WIDTH + 1;      // parity bit kept in the MSB
`else
  localparam int MW = INSTR_WIDTH;
`endif

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic                   misalign;
    logic                   bus_err;
  } rsp_t;

  typedef struct packed {
    logic valid;
    rsp_t data;
  } beat_t;

  logic [MW-1:0]       mem [MEM_DEPTH];
  logic [PC_WIDTH:0]   diff;
  logic [PC_WIDTH-1:0] word_off;
  logic [AW-1:0]       idx;
  logic                misalign;
  logic                out_of_range;
  logic                par_err;
  logic [MW-1:0]       rd_word;
  logic                accept;
  beat_t               acc_beat;
  beat_t               tail;
  logic [CW-1:0]       pipe_cnt;
  logic [CW-1:0]       fifo_cnt;
  logic [CW-1:0]       inflight;
  rsp_t                fifo_q [FIFO_D];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                push;
  logic                pop;

  // Loader write; the fetch read below sees the pre-write word (read-first).
  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
`ifdef IF_MEM_PARITY_EN
      mem[ld_addr_i] <= {(^ld_data_i) ^ ld_par_inj_i, ld_data_i};
`else
      mem[ld_addr_i] <= ld_data_i;
`endif
    end
  end

  // Address decode and array read for the request being offered this cycle.
  always_comb begin
    diff         = {1'b0, req_pc_i} - {1'b0, BASE_ADDR};  // MSB set = below base
    word_off     = diff[PC_WIDTH-1:0] >> 2;
    idx          = word_off[AW-1:0];
    misalign     = (req_pc_i[1:0] != 2'b00);
    out_of_range = diff[PC_WIDTH] || (word_off >= DEPTH_W);
    rd_word      = mem[idx];
`ifdef IF_MEM_PARITY_EN
    par_err      = ^rd_word;
`else
    par_err      = 1'b0;
`endif
    acc_beat.valid         = accept;
    acc_beat.data.instr    = NOP_INSTR;
    acc_beat.data.misalign = misalign;
    acc_beat.data.bus_err  = 1'b0;
    if (!misalign) begin
      if (out_of_range || par_err) begin
        acc_beat.data.bus_err = 1'b1;
      end else begin
        acc_beat.data.instr = rd_word[INSTR_WIDTH-1:0];
      end
    end
  end

  // Credit: every accepted request holds a slot until it is popped, so the
  // FIFO can never overflow even though the pipeline never stalls.
  always_comb begin
    inflight    = pipe_cnt + fifo_cnt;
    req_ready_o = (inflight < CW'(FIFO_D));
    accept      = req_valid_i & req_ready_o;
  end

  // The FIFO write is the last latency stage; extra stages only when RD_LATENCY > 1.
  if (PIPE_N == 0) begin : g_no_pipe
    assign tail     = acc_beat;
    assign pipe_cnt = '0;
  end else begin : g_pipe
    beat_t         stage [PIPE_N];
    logic [CW-1:0] cnt;

    // Free-running shift of the read pipeline; reset drops in-flight beats.
    always_ff @(posedge clk_i) begin
      stage[0] <= acc_beat;
      for (int i = 1; i < PIPE_N; i++) begin
        stage[i] <= stage[i-1];
      end
      if (rst_i) begin
        for (int i = 0; i < PIPE_N; i++) begin
          stage[i].valid <= 1'b0;
        end
      end
    end

    // Count occupied pipeline stages for the credit check.
    always_comb begin
      cnt = '0;
      for (int i = 0; i < PIPE_N; i++) begin
        cnt = cnt + CW'(stage[i].valid);
      end
    end

    assign pipe_cnt = cnt;
    assign tail     = stage[PIPE_N-1];
  end

  assign push = tail.valid;
  assign pop  = rsp_valid_o & rsp_ready_i;

  // Output FIFO pointers, occupancy and storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= tail.data;
        wr_ptr <= (wr_ptr == PW'(FIFO_D - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_D - 1)) ? '0 : rd_ptr + 1'b1;
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // Response driven from the FIFO head; idle value is a clean NOP.
  always_comb begin
    rsp_valid_o    = (fifo_cnt != '0);
    rsp_instr_o    = NOP_INSTR;
    rsp_misalign_o = 1'b0;
    rsp_bus_err_o  = 1'b0;
    if (rsp_valid_o) begin
      rsp_instr_o    = fifo_q[rd_ptr].instr;
      rsp_misalign_o = fifo_q[rd_ptr].misalign;
      rsp_bus_err_o  = fifo_q[rd_ptr].bus_err;
    end
  end

endmodule

// File: tb/tb_if_mem_resp.sv
// tb_if_mem_resp: bench for if_mem_resp with a queue-based response model.
module tb_if_mem_resp;

  localparam int          L      = 1;
  localparam int          IW     = 32;
  localparam int          DEPTH  = 1024;
  localparam int          LOADED = 64;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          EW     = 32 + IW + 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready_o;
  logic [31:0] req_pc;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [31:0] rsp_instr_o;
  logic        rsp_misalign_o;
  logic        rsp_bus_err_o;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_par_inj;

  if_mem_resp #(
    .PC_WIDTH(32), .INSTR_WIDTH(IW), .MEM_DEPTH(DEPTH),
    .BASE_ADDR(32'h0000_0000), .RD_LATENCY(L), .NOP_INSTR(NOP)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_pc_i(req_pc),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_instr_o(rsp_instr_o),
    .rsp_misalign_o(rsp_misalign_o), .rsp_bus_err_o(rsp_bus_err_o),
`ifdef IF_MEM_PARITY_EN
    .ld_par_inj_i(ld_par_inj),
`endif
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem    [LOADED];
  logic        m_par_ok [LOADED];
  logic [EW-1:0] exp_q [$];   // {visible_cycle, instr, misalign, bus_err}

  // Response a fetch of pc must produce, from the address rules (base is 0).
  function automatic logic [IW+1:0] m_decode(input logic [31:0] pc);
    logic [31:0] w;
    if (pc[1:0] != 2'b00) return {NOP, 2'b10};
    w = pc >> 2;
    if (w >= DEPTH) return {NOP, 2'b01};
    if (!m_par_ok[w[5:0]]) return {NOP, 2'b01};
    return {m_mem[w[5:0]], 2'b00};
  endfunction

  int            cyc = 0;
  bit            was_rst = 1'b1;
  bit            m_ready;
  bit            m_valid;
  logic [EW-1:0] head;

  // Compare outputs against the model every cycle, then advance the model
  // by what will happen at the coming rising edge.
  always @(negedge clk) begin
    cyc++;
    m_ready = (exp_q.size() < L + 1);
    m_valid = 1'b0;
    if (exp_q.size() != 0) begin
      head    = exp_q[0];
      m_valid = (int'(head[EW-1:IW+2]) <= cyc);
    end
    if (was_rst) begin
      chk("reset_req_ready", 64'(req_ready_o), 64'd1);
      chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("reset_rsp_instr", 64'(rsp_instr_o), 64'(NOP));
      chk("reset_rsp_flags", 64'({rsp_misalign_o, rsp_bus_err_o}), 64'd0);
    end else begin
      chk("req_ready", 64'(req_ready_o), 64'(m_ready));
      chk("rsp_valid", 64'(rsp_valid_o), 64'(m_valid));
      if (m_valid && rsp_valid_o) begin
        chk("rsp_instr", 64'(rsp_instr_o), 64'(head[IW+1:2]));
        chk("rsp_flags", 64'({rsp_misalign_o, rsp_bus_err_o}), 64'(head[1:0]));
      end
    end
    if (rst) begin
      exp_q.delete();
      was_rst = 1'b1;
    end else begin
      was_rst = 1'b0;
      if (m_valid && rsp_ready) void'(exp_q.pop_front());
      if (req_valid && m_ready) exp_q.push_back({32'(cyc + L), m_decode(req_pc)});
      if (ld_we && ld_addr < LOADED) begin
        m_mem[ld_addr[5:0]]    = ld_data;
        m_par_ok[ld_addr[5:0]] = !ld_par_inj;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] data, input logic inj);
    ld_we = 1'b1; ld_addr = 10'(idx); ld_data = data; ld_par_inj = inj;
    step();
    ld_we = 1'b0; ld_par_inj = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc);
    bit acc;
    int guard;
    req_valid = 1'b1; req_pc = pc; acc = 1'b0; guard = 0;
    while (!acc && guard < 64) begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      n_vec++; n_miss++;
      $display("FAIL issue_timeout: pc %0h not accepted, got ready=0, expected 1", pc);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    req_valid = 1'b0; rsp_ready = 1'b1; guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int          accepts;
  int          r;
  logic [31:0] ld_words [4];

  initial begin
    ld_words[0] = 32'h0050_0093; ld_words[1] = 32'h0010_0113;
    ld_words[2] = 32'h0020_81b3; ld_words[3] = 32'h0000_006f;
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_par_inj = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    for (int i = 0; i < LOADED; i++) begin
      load(i, (i < 4) ? ld_words[i] : $urandom, 1'b0);
    end

    // Pin the model against hand-computed values.
    chk("model_pc0",      64'(m_decode(32'h0)),    64'({32'h0050_0093, 2'b00}));
    chk("model_pc8",      64'(m_decode(32'h8)),    64'({32'h0020_81b3, 2'b00}));
    chk("model_misalign", 64'(m_decode(32'h6)),    64'({32'h0000_0013, 2'b10}));
    chk("model_oob",      64'(m_decode(32'h1000)), 64'({32'h0000_0013, 2'b01}));

    // First response one latency after acceptance.
    issue(32'h0);
    @(negedge clk);
    chk("first_rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("first_rsp_instr", 64'(rsp_instr_o), 64'h0050_0093);
    step();

    // Back-to-back in-order fetch.
    for (int i = 0; i < 4; i++) issue(32'(i * 4));
    drain();

    // Error decode.
    issue(32'h6);
    @(negedge clk);
    chk("misalign_rsp", 64'({rsp_instr_o, rsp_misalign_o, rsp_bus_err_o}), 64'({32'h13, 2'b10}));
    step();
    issue(32'h1000);
    @(negedge clk);
    chk("bus_err_rsp", 64'({rsp_instr_o, rsp_misalign_o, rsp_bus_err_o}), 64'({32'h13, 2'b01}));
    step();
    issue(32'hFFFF_FFFC);
    drain();

    // Stall: only L+1 requests can be outstanding.
    rsp_ready = 1'b0; req_valid = 1'b1; accepts = 0;
    for (int i = 0; i < 6; i++) begin
      req_pc = 32'(i * 4);
      @(negedge clk);
      if (req_ready_o) accepts++;
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("stall_accepts", 64'(accepts), 64'(L + 1));
    chk("stall_ready_low", 64'(req_ready_o), 64'd0);
    chk("stall_head", 64'(rsp_instr_o), 64'h0050_0093);
    step();
    drain();

    // Same-cycle write and fetch of index 2: read-first.
    ld_we = 1'b1; ld_addr = 10'd2; ld_data = 32'hDEAD_BEEF;
    issue(32'h8);
    ld_we = 1'b0;
    @(negedge clk);
    chk("read_first_old", 64'(rsp_instr_o), 64'h0020_81b3);
    step();
    issue(32'h8);
    @(negedge clk);
    chk("read_after_write", 64'(rsp_instr_o), 64'hDEAD_BEEF);
    step();
    drain();

    // Reset with two requests in flight: they must never come out.
    rsp_ready = 1'b0;
    issue(32'h0);
    issue(32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 64'(req_ready_o), 64'd1);
    chk("post_reset_valid", 64'(rsp_valid_o), 64'd0);
    step();
    rsp_ready = 1'b1;
    repeat (5) step();

`ifdef IF_MEM_PARITY_EN
    load(5, 32'h1234_5678, 1'b1);
    issue(32'h14);
    @(negedge clk);
    chk("parity_err_rsp", 64'({rsp_instr_o, rsp_misalign_o, rsp_bus_err_o}), 64'({32'h13, 2'b01}));
    step();
    drain();
    load(5, 32'h1234_5678, 1'b0);
`endif

    // Randomized traffic with concurrent loader writes.
    for (int i = 0; i < 2000; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)       req_pc = {24'd0, 6'($urandom_range(0, LOADED - 1)), 2'b00};
      else if (r == 7) req_pc = {24'd0, 6'($urandom_range(0, LOADED - 1)), 2'($urandom_range(1, 3))};
      else if (r == 8) req_pc = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      else             req_pc = {$urandom_range(1024, 32'h3FFF_FFFF), 2'b00};
      ld_we      = ($urandom_range(0, 7) == 0);
      ld_addr    = 10'($urandom_range(0, LOADED - 1));
      ld_data    = $urandom;
`ifdef IF_MEM_PARITY_EN
      ld_par_inj = ld_we && ($urandom_range(0, 3) == 0);
`endif
      step();
    end
    ld_we = 1'b0; ld_par_inj = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
